// File: rtl/procb_thread_sched_pkg.sv
// Shared types for the process_bytes thread scheduler: per-thread lifecycle
// encoding and the width of the procb_saved_state word.
package procb_thread_sched_pkg;

    localparam int PROCB_SAVE_MSB = 63;

    typedef enum logic [1:0] {
        TS_IDLE  = 2'd0,
        TS_READY = 2'd1,
        TS_BUSY  = 2'd2,
        TS_DONE  = 2'd3
    } thr_state_t;

endpackage

// File: rtl/procb_thread_sched_if.sv
// Loader / process_bytes / consumer / memory-write bundle of the thread scheduler.
// The slave modport is the scheduler side.
interface procb_thread_sched_if #(
    parameter int N_THREADS_MSB = 3
);
    import procb_thread_sched_pkg::*;

    logic                     load_en;
    logic [N_THREADS_MSB:0]   load_thread_num;
    logic [PROCB_SAVE_MSB:0]  load_din;
    logic                     load_ready;
    logic                     save_en;
    logic [N_THREADS_MSB:0]   save_thread_num;
    logic [PROCB_SAVE_MSB:0]  save_din;
    logic                     save_done;
    logic                     release_en;
    logic [N_THREADS_MSB:0]   release_thread_num;
    logic                     sched_valid;
    logic [N_THREADS_MSB:0]   sched_thread_num;
    logic                     sched_ready;
    logic                     mem_wr_en;
    logic [N_THREADS_MSB:0]   mem_wr_thread_num;
    logic [PROCB_SAVE_MSB:0]  mem_wr_din;
    logic [N_THREADS_MSB+1:0] ready_cnt;

    modport master (
        output load_en, load_thread_num, load_din,
        output save_en, save_thread_num, save_din, save_done,
        output release_en, release_thread_num, sched_ready,
        input  load_ready, sched_valid, sched_thread_num,
        input  mem_wr_en, mem_wr_thread_num, mem_wr_din, ready_cnt
    );

    modport slave (
        input  load_en, load_thread_num, load_din,
        input  save_en, save_thread_num, save_din, save_done,
        input  release_en, release_thread_num, sched_ready,
        output load_ready, sched_valid, sched_thread_num,
        output mem_wr_en, mem_wr_thread_num, mem_wr_din, ready_cnt
    );

endinterface

// File: rtl/procb_thread_sched_rr_select.sv
// Round-robin priority encoder: first set bit of ready_mask at or after ptr,
// wrapping modulo N_THREADS (power of 2).
module procb_rr_select #(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
    input  logic [N_THREADS-1:0] ready_mask,
    input  logic [N_THREADS_MSB:0] ptr,
    output logic                 found,
    output logic [N_THREADS_MSB:0] idx
);

    logic [N_THREADS_MSB:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            cand = ptr + (N_THREADS_MSB+1)'(i);
            if (!found && ready_mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/procb_thread_sched.sv
// Thread lifecycle tracker, round-robin grant to process_bytes and saved-state
// write-port arbiter. Optional sticky sched_err under PROCB_SCHED_CHECK_EN.
module procb_thread_sched
    import procb_thread_sched_pkg::*;
#(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
    input  logic CLK,
    input  logic RESET_N,
    procb_thread_sched_if.slave bus
`ifdef PROCB_SCHED_CHECK_EN
    ,
    output logic sched_err
`endif
);

    thr_state_t               st_q [N_THREADS];
    thr_state_t               st_d [N_THREADS];
    logic [N_THREADS_MSB:0]   ptr_q;
    logic                     sched_vld_p1;
    logic [N_THREADS_MSB:0]   sched_num_p1;
    logic                     mem_wr_en_p1;
    logic [N_THREADS_MSB:0]   mem_wr_num_p1;
    logic [PROCB_SAVE_MSB:0]  mem_wr_din_p1;
    logic [N_THREADS_MSB+1:0] ready_cnt_p1;
    logic [N_THREADS_MSB+1:0] ready_cnt_d;
    logic [N_THREADS-1:0]     ready_mask;
    logic                     rr_found;
    logic [N_THREADS_MSB:0]   rr_idx;
    logic                     hs;
    logic                     load_ok;
    logic                     save_ok;
    logic                     rel_ok;

    // Save owns the write port; a colliding load is refused and must be held.
    assign bus.load_ready = !bus.save_en;
    assign hs      = sched_vld_p1 && bus.sched_ready;
    assign load_ok = bus.load_en && !bus.save_en && (st_q[bus.load_thread_num] == TS_IDLE);
    assign save_ok = bus.save_en && (st_q[bus.save_thread_num] == TS_BUSY);
    assign rel_ok  = bus.release_en && (st_q[bus.release_thread_num] == TS_DONE);

    always_comb begin
        for (int i = 0; i < N_THREADS; i++) st_d[i] = st_q[i];
        if (load_ok) st_d[bus.load_thread_num]    = TS_READY;
        if (hs)      st_d[sched_num_p1]           = TS_BUSY;
        if (save_ok) st_d[bus.save_thread_num]    = bus.save_done ? TS_DONE : TS_READY;
        if (rel_ok)  st_d[bus.release_thread_num] = TS_IDLE;
        ready_cnt_d = '0;
        ready_mask  = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            ready_mask[i] = (st_q[i] == TS_READY);
            if (st_d[i] == TS_READY) ready_cnt_d = ready_cnt_d + (N_THREADS_MSB+2)'(1);
        end
    end

    procb_rr_select #(
        .N_THREADS     (N_THREADS),
        .N_THREADS_MSB (N_THREADS_MSB)
    ) u_rr (
        .ready_mask (ready_mask),
        .ptr        (ptr_q),
        .found      (rr_found),
        .idx        (rr_idx)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_THREADS; i++) st_q[i] <= TS_IDLE;
            ready_cnt_p1 <= '0;
        end else begin
            for (int i = 0; i < N_THREADS; i++) st_q[i] <= st_d[i];
            ready_cnt_p1 <= ready_cnt_d;
        end
    end

    // Offer is latched and held until taken; a grant forces one bubble so the
    // next pick sees the granted thread already BUSY and the advanced pointer.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_q        <= '0;
            sched_vld_p1 <= 1'b0;
            sched_num_p1 <= '0;
        end else if (hs) begin
            sched_vld_p1 <= 1'b0;
            ptr_q        <= sched_num_p1 + (N_THREADS_MSB+1)'(1);
        end else if (!sched_vld_p1 && rr_found) begin
            sched_vld_p1 <= 1'b1;
            sched_num_p1 <= rr_idx;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_wr_en_p1  <= 1'b0;
            mem_wr_num_p1 <= '0;
            mem_wr_din_p1 <= '0;
        end else begin
            mem_wr_en_p1 <= save_ok || load_ok;
            if (save_ok) begin
                mem_wr_num_p1 <= bus.save_thread_num;
                mem_wr_din_p1 <= bus.save_din;
            end else if (load_ok) begin
                mem_wr_num_p1 <= bus.load_thread_num;
                mem_wr_din_p1 <= bus.load_din;
            end
        end
    end

    assign bus.sched_valid       = sched_vld_p1;
    assign bus.sched_thread_num  = sched_num_p1;
    assign bus.mem_wr_en         = mem_wr_en_p1;
    assign bus.mem_wr_thread_num = mem_wr_num_p1;
    assign bus.mem_wr_din        = mem_wr_din_p1;
    assign bus.ready_cnt         = ready_cnt_p1;

`ifdef PROCB_SCHED_CHECK_EN
    logic err_ev;

    assign err_ev = (bus.load_en && bus.load_ready && (st_q[bus.load_thread_num] != TS_IDLE))
                 || (bus.save_en && (st_q[bus.save_thread_num] != TS_BUSY))
                 || (bus.release_en && (st_q[bus.release_thread_num] != TS_DONE))
                 || (bus.sched_ready && !sched_vld_p1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)    sched_err <= 1'b0;
        else if (err_ev) sched_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_procb_thread_sched.sv
// Scoreboard bench for procb_thread_sched: expected memory writes and grants are
// queued by the stimulus and retired by a negedge monitor.
module tb_procb_thread_sched;
    import procb_thread_sched_pkg::*;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   checks = 0;
    int   failures = 0;
`ifdef PROCB_SCHED_CHECK_EN
    logic sched_err;
`endif

    procb_thread_sched_if #(.N_THREADS_MSB(3)) bus ();

    procb_thread_sched #(.N_THREADS(16)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
`ifdef PROCB_SCHED_CHECK_EN
        ,
        .sched_err (sched_err)
`endif
    );

    always #5 CLK = ~CLK;

    logic [63:0] mem [16];
    int          wq_thr[$];
    logic [63:0] wq_dat[$];
    int          gq_thr[$];
    logic [63:0] gq_dat[$];

    always @(posedge CLK) if (bus.mem_wr_en) mem[bus.mem_wr_thread_num] <= bus.mem_wr_din;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: retire expected writes and grants as the DUT presents them.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (bus.mem_wr_en) begin
                if (wq_thr.size() == 0) chk("unexpected_wr", 64'(bus.mem_wr_thread_num), 64'hFFFF);
                else begin
                    chk("wr_thread", 64'(bus.mem_wr_thread_num), 64'(wq_thr.pop_front()));
                    chk("wr_data", bus.mem_wr_din, wq_dat.pop_front());
                end
            end
            if (bus.sched_valid && bus.sched_ready) begin
                if (gq_thr.size() == 0) chk("unexpected_grant", 64'(bus.sched_thread_num), 64'hFFFF);
                else begin
                    chk("grant_thread", 64'(bus.sched_thread_num), 64'(gq_thr.pop_front()));
                    chk("grant_mem_data", mem[bus.sched_thread_num], gq_dat.pop_front());
                end
            end
        end
    end

    function automatic logic [63:0] dv(input int thr, input logic [31:0] tag);
        return {tag, 32'(thr)};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        bus.load_en = 0; bus.load_thread_num = '0; bus.load_din = '0;
        bus.save_en = 0; bus.save_thread_num = '0; bus.save_din = '0; bus.save_done = 0;
        bus.release_en = 0; bus.release_thread_num = '0; bus.sched_ready = 0;
    endtask

    task automatic load(input int thr, input logic [63:0] d, input bit expect_wr);
        bus.load_en = 1; bus.load_thread_num = 4'(thr); bus.load_din = d;
        if (expect_wr) begin wq_thr.push_back(thr); wq_dat.push_back(d); end
    endtask

    task automatic save(input int thr, input logic [63:0] d, input bit done, input bit expect_wr);
        bus.save_en = 1; bus.save_thread_num = 4'(thr); bus.save_din = d; bus.save_done = done;
        if (expect_wr) begin wq_thr.push_back(thr); wq_dat.push_back(d); end
    endtask

    task automatic take(input int thr, input logic [63:0] d);
        int n = 0;
        gq_thr.push_back(thr); gq_dat.push_back(d);
        while (!bus.sched_valid && n < 20) begin step(); n++; end
        if (!bus.sched_valid) begin
            void'(gq_thr.pop_back()); void'(gq_dat.pop_back());
            chk("grant_timeout", 64'(bus.sched_valid), 64'd1);
        end else begin
            bus.sched_ready = 1;
            step();
            bus.sched_ready = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr();
        step(); step();
        chk("rst_valid", 64'(bus.sched_valid), 0);
        chk("rst_num", 64'(bus.sched_thread_num), 0);
        chk("rst_wr_en", 64'(bus.mem_wr_en), 0);
        chk("rst_wr_num", 64'(bus.mem_wr_thread_num), 0);
        chk("rst_wr_din", bus.mem_wr_din, 0);
        chk("rst_ready_cnt", 64'(bus.ready_cnt), 0);
        chk("rst_load_ready", 64'(bus.load_ready), 1);
        RESET_N = 1;
        step();

        // Loads of 3 and 5: offer at t+2, grant, one bubble, then 5.
        load(3, dv(3, 32'hA), 1); step();
        load(5, dv(5, 32'hA), 1);
        chk("t1_valid_t+1", 64'(bus.sched_valid), 0);
        step(); clr();
        chk("t1_valid_t+2", 64'(bus.sched_valid), 1);
        chk("t1_offer3", 64'(bus.sched_thread_num), 3);
        chk("t1_ready_cnt2", 64'(bus.ready_cnt), 2);
        take(3, dv(3, 32'hA));
        chk("t1_bubble", 64'(bus.sched_valid), 0);
        chk("t1_ready_cnt1", 64'(bus.ready_cnt), 1);
        step();
        chk("t1_valid_after_bubble", 64'(bus.sched_valid), 1);
        chk("t1_offer5", 64'(bus.sched_thread_num), 5);
        take(5, dv(5, 32'hA));

        // Save and load collide: save wins, load accepted next cycle.
        save(3, dv(3, 32'hB), 0, 1);
        load(9, dv(9, 32'hA), 0);
        #1;
        chk("t2_load_ready_blocked", 64'(bus.load_ready), 0);
        step();
        bus.save_en = 0;
        wq_thr.push_back(9); wq_dat.push_back(dv(9, 32'hA));
        chk("t2_wr_en", 64'(bus.mem_wr_en), 1);
        chk("t2_wr_thread_is_save", 64'(bus.mem_wr_thread_num), 3);
        step(); clr();
        take(3, dv(3, 32'hB));
        take(9, dv(9, 32'hA));

        // Thread 7 returns to READY and is re-offered with its saved state.
        load(7, dv(7, 32'hA), 1); step(); clr();
        take(7, dv(7, 32'hA));
        save(7, dv(7, 32'hC), 0, 1); step(); clr();
        chk("t3_valid_t+1", 64'(bus.sched_valid), 0);
        step();
        chk("t3_valid_t+2", 64'(bus.sched_valid), 1);
        chk("t3_offer7", 64'(bus.sched_thread_num), 7);
        take(7, dv(7, 32'hC));

        // Thread 2 finishes: never offered, rejects loads until released.
        load(2, dv(2, 32'hA), 1); step(); clr();
        take(2, dv(2, 32'hA));
        save(2, dv(2, 32'hD), 1, 1); step(); clr();
        load(2, dv(2, 32'hBAD), 0); step(); clr();
        step(); step();
        chk("t4_done_not_offered", 64'(bus.sched_valid), 0);
        chk("t4_ready_cnt0", 64'(bus.ready_cnt), 0);
        bus.release_en = 1; bus.release_thread_num = 4'd2; step(); clr();
        load(2, dv(2, 32'hE), 1); step(); clr();
        take(2, dv(2, 32'hE));

        // Asynchronous reset while thread 6 is offered.
        load(6, dv(6, 32'hA), 1); step(); clr(); step();
        chk("t5_pre_rst_valid", 64'(bus.sched_valid), 1);
        chk("t5_pre_rst_num", 64'(bus.sched_thread_num), 6);
        chk("t5_pre_rst_cnt", 64'(bus.ready_cnt), 1);
        #2 RESET_N = 0;
        #1;
        chk("t5_rst_valid", 64'(bus.sched_valid), 0);
        chk("t5_rst_num", 64'(bus.sched_thread_num), 0);
        chk("t5_rst_cnt", 64'(bus.ready_cnt), 0);
`ifdef PROCB_SCHED_CHECK_EN
        chk("t5_rst_err", 64'(sched_err), 0);
`endif
        step();
        RESET_N = 1;
        step();

        // Save to an IDLE thread is ignored (no write queued).
        save(12, dv(12, 32'hF), 0, 0); step(); clr(); step();
`ifdef PROCB_SCHED_CHECK_EN
        chk("t6_err_set", 64'(sched_err), 1);
`endif

        // All 16 READY with ptr=15: grants 15, 0, 1.
        load(14, dv(14, 32'hA), 1); step(); clr();
        take(14, dv(14, 32'hA));
        load(15, dv(15, 32'hA), 1); step(); clr();
        save(14, dv(14, 32'hB), 0, 1); step(); clr();
        for (int t = 0; t < 14; t++) begin
            load(t, dv(t, 32'hA), 1); step(); clr();
        end
        step();
        chk("t7_ready_cnt16", 64'(bus.ready_cnt), 16);
        chk("t7_offer_stable15", 64'(bus.sched_thread_num), 15);
        take(15, dv(15, 32'hA));
        take(0, dv(0, 32'hA));
        take(1, dv(1, 32'hA));
        step(); step();
        chk("wr_queue_drained", 64'(wq_thr.size()), 0);
        chk("grant_queue_drained", 64'(gq_thr.size()), 0);
`ifdef PROCB_SCHED_CHECK_EN
        chk("t7_err_sticky", 64'(sched_err), 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
